// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RV32I control path:
// FSM states, opcodes, mux-select encodings and the per-state Moore output table.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    JAL,
    ALUWB,
    BEQ
  } statetype;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

  // Pure Moore part; the mem_ready/Zero gated enables are added at the top level.
  function automatic ctrl_t moore_outputs(input statetype s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALURESULT;
      end
      DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
      end
      MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
      end
      EXECUTER: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_write   = 1'b1;
      end
      ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      BEQ: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       illegal;

  modport master (
    input  op, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal
  );

  modport slave (
    output op, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal
  );
endinterface

// File: rtl/instr_imm_dec.sv
// Immediate-format decoder: selects the ImmExt format directly from the opcode.
module instr_imm_dec
  import riscv_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    // NOTE: default assignment first so no path leaves imm_src unassigned (no latch).
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives every datapath enable and mux select.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter statetype RESET_STATE = FETCH
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  statetype   state_q, state_d;
  ctrl_t      moore_q, moore_d;
  ctrl_t      ctrl;
  logic       illegal;
  logic [1:0] imm_src_raw;
  logic [1:0] imm_src;

  instr_imm_dec u_imm_dec (
    .op      (bus.op),
    .imm_src (imm_src_raw)
  );

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (bus.op == OP_LW)      state_d = MEMREAD;
        else if (bus.op == OP_SW) state_d = MEMWRITE;
        else                      state_d = FETCH;
      end
      MEMREAD:  state_d = bus.mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = bus.mem_ready ? FETCH : MEMWRITE;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      default:  state_d = FETCH;
    endcase
    moore_d = moore_outputs(state_d);
  end

  // Moore outputs are registered alongside the state so they always match state_q.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q <= RESET_STATE;
      moore_q <= moore_outputs(RESET_STATE);
    end else begin
      state_q <= state_d;
      moore_q <= moore_d;
    end
  end

  // Three combinational terms layered on the registered Moore outputs; reset
  // low blanks everything so an abandoned instruction fires no enable.
  always_comb begin
    ctrl    = moore_q;
    illegal = 1'b0;
    imm_src = imm_src_raw;
    if (state_q == FETCH) begin
      ctrl.ir_write = bus.mem_ready;
      ctrl.pc_write = bus.mem_ready;
    end
    if (state_q == BEQ) ctrl.pc_write = bus.Zero;
    if (state_q == DECODE) illegal = !is_supported(bus.op);
    if (!reset) begin
      ctrl    = '0;
      illegal = 1'b0;
      imm_src = 2'b00;
    end
  end

  assign bus.PCWrite   = ctrl.pc_write;
  assign bus.AdrSrc    = ctrl.adr_src;
  assign bus.MemWrite  = ctrl.mem_write;
  assign bus.IRWrite   = ctrl.ir_write;
  assign bus.RegWrite  = ctrl.reg_write;
  assign bus.ResultSrc = ctrl.result_src;
  assign bus.ALUSrcA   = ctrl.alu_src_a;
  assign bus.ALUSrcB   = ctrl.alu_src_b;
  assign bus.ALUOp     = ctrl.alu_op;
  assign bus.ImmSrc    = imm_src;
  assign bus.illegal   = illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: an instruction-level model
// expands each instruction into its per-cycle control words; a monitor compares them.
module tb_multicycle_controller;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;

  typedef struct packed {
    logic       pcw, adr, memw, irw, regw, ill;
    logic [1:0] res, srca, srcb, aluop, imm;
  } ctl_t;

  typedef struct {
    ctl_t  v;
    string tag;
  } exp_t;

  typedef struct {
    string name;
    logic  mr;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [6:0] op);
    return op inside {T_LW, T_SW, T_R, T_I, T_BEQ, T_JAL};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == T_SW)  return 2'b01;
    if (op == T_BEQ) return 2'b10;
    if (op == T_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Control word the datapath must see in one cycle of a given instruction step.
  function automatic ctl_t model(input string step, input logic [6:0] op,
                                 input logic zero, input logic mr);
    ctl_t c;
    c     = '0;
    c.imm = imm_of(op);
    case (step)
      "fetch":    begin c.srcb = 2'b10; c.res = 2'b10; c.irw = mr; c.pcw = mr; end
      "decode":   begin c.srca = 2'b01; c.srcb = 2'b01; c.ill = !legal(op); end
      "memadr":   begin c.srca = 2'b10; c.srcb = 2'b01; end
      "memread":  c.adr = 1'b1;
      "memwb":    begin c.res = 2'b01; c.regw = 1'b1; end
      "memwrite": begin c.adr = 1'b1; c.memw = 1'b1; end
      "execr":    begin c.srca = 2'b10; c.aluop = 2'b10; end
      "execi":    begin c.srca = 2'b10; c.srcb = 2'b01; c.aluop = 2'b10; end
      "jal":      begin c.srca = 2'b01; c.srcb = 2'b10; c.pcw = 1'b1; end
      "aluwb":    c.regw = 1'b1;
      "beq":      begin c.srca = 2'b10; c.aluop = 2'b01; c.pcw = zero; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  task automatic do_cycle(input string step, input logic zero, input logic mr, input logic rst);
    exp_t e;
    reset         = rst;
    bus.Zero      = zero;
    bus.mem_ready = mr;
    e.v   = rst ? model(step, bus.op, zero, mr) : ctl_t'('0);
    e.tag = step;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic push_wait(inout step_t q[$], input string name, input int waits);
    step_t s;
    for (int k = 0; k < waits; k++) begin
      s.name = name; s.mr = 1'b0; q.push_back(s);
    end
    s.name = name; s.mr = 1'b1; q.push_back(s);
  endtask

  task automatic push_step(inout step_t q[$], input string name);
    step_t s;
    s.name = name;
    s.mr   = 1'($urandom % 2);
    q.push_back(s);
  endtask

  // One instruction: fetch wait wf, memory wait wm; reset asserted for rst_len
  // cycles in place of step abort_at (abort_at < 0 means run to completion).
  task automatic run_instr(input logic [6:0] op, input logic zero_beq, input int wf,
                           input int wm, input int abort_at, input int rst_len);
    step_t steps[$];
    logic  z;
    bus.op = op;
    push_wait(steps, "fetch", wf);
    push_step(steps, "decode");
    case (op)
      T_LW:  begin push_step(steps, "memadr"); push_wait(steps, "memread", wm);
                   push_step(steps, "memwb"); end
      T_SW:  begin push_step(steps, "memadr"); push_wait(steps, "memwrite", wm); end
      T_R:   begin push_step(steps, "execr"); push_step(steps, "aluwb"); end
      T_I:   begin push_step(steps, "execi"); push_step(steps, "aluwb"); end
      T_JAL: begin push_step(steps, "jal"); push_step(steps, "aluwb"); end
      T_BEQ: push_step(steps, "beq");
      default: ;
    endcase
    foreach (steps[i]) begin
      if (i == abort_at) begin
        for (int r = 0; r < rst_len; r++)
          do_cycle("reset", 1'($urandom % 2), 1'($urandom % 2), 1'b0);
        return;
      end
      z = (steps[i].name == "beq") ? zero_beq : 1'($urandom % 2);
      do_cycle(steps[i].name, z, steps[i].mr, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    ctl_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{pcw: bus.PCWrite, adr: bus.AdrSrc, memw: bus.MemWrite, irw: bus.IRWrite,
            regw: bus.RegWrite, ill: bus.illegal, res: bus.ResultSrc, srca: bus.ALUSrcA,
            srcb: bus.ALUSrcB, aluop: bus.ALUOp, imm: bus.ImmSrc};
      check(e.tag, 32'(a), 32'(e.v));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete, %0d entries pending", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ops[7];
    logic [6:0] op;
    int         sel;
    ops = '{T_LW, T_SW, T_R, T_I, T_BEQ, T_JAL, 7'b0};
    reset = 1'b0; bus.op = '0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_cycle("reset", 1'b1, 1'b1, 1'b0);
    do_cycle("reset", 1'b0, 1'b1, 1'b0);

    run_instr(T_R, 1'b0, 0, 0, 2, 2);           // reset held two cycles in EXECUTER
    run_instr(T_R, 1'b0, 0, 0, -1, 0);
    run_instr(T_LW, 1'b0, 0, 3, -1, 0);
    run_instr(T_BEQ, 1'b1, 0, 0, -1, 0);
    run_instr(T_BEQ, 1'b0, 0, 0, -1, 0);
    run_instr(T_SW, 1'b0, 0, 2, -1, 0);
    run_instr(T_JAL, 1'b0, 0, 0, -1, 0);
    run_instr(7'b1111111, 1'b0, 0, 0, -1, 0);
    run_instr(T_I, 1'b0, 2, 0, -1, 0);

    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom % 7);
      op  = ops[sel];
      if (sel == 6) begin
        do op = 7'($urandom); while (legal(op));
      end
      run_instr(op, 1'($urandom % 2), int'($urandom % 4), int'($urandom % 4),
                ($urandom % 10 == 0) ? int'($urandom % 6) : -1, 1 + int'($urandom % 2));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
